speed_test_sequencer: RTL
=========================

# speed_test_sequencer

Run sequencer for the speed tester: accepts one test command (port mask, duration in ms), waits for the selected frame generators and checkers to report ready, pulses `start`, times the run with a millisecond prescaler, pulses `stop`, then waits for the checkers to settle before reporting completion with a status code. It sits between the `speed_test_controller` register file (command source) and the per-port generator/checker pairs. It replaces software-timed start/stop with cycle-exact hardware timing.

## Interface
- `TEST_PORT_NUM`, 4: number of test ports.
- `CLOCK_FREQ`, 125000000: `clk` frequency in Hz. Must be a multiple of 1000.
- `DURATION_WIDTH`, 16: width of duration and elapsed counters, in ms.
- `READY_TIMEOUT_MS`, 100: ready-wait limit, in ms.
- `DRAIN_MIN_CYCLES`, 16: minimum number of cycles after `stop` before checker ready is sampled.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_port_mask`  in  TEST_PORT_NUM  ports under test.
- `cmd_duration_ms`  in  DURATION_WIDTH  run length; 0 = run until abort.
- `abort`  in  1  single-cycle abort request.
- `gen_ready`  in  TEST_PORT_NUM  generator idle/ready.
- `check_ready`  in  TEST_PORT_NUM  checker idle/results valid.
- `start`  out  TEST_PORT_NUM  one-cycle start pulse per masked port.
- `stop`  out  TEST_PORT_NUM  one-cycle stop pulse per masked port.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `status`  out  2  0 = OK, 1 = ABORTED, 2 = TIMEOUT. Held until the next command is accepted.
- `elapsed_ms`  out  DURATION_WIDTH  ms elapsed in RUN. Held after done.

## Operation
- **States:** IDLE, WAIT_READY, RUN, DRAIN, DONE.
- **IDLE:**
  - On `cmd_valid & cmd_ready`, latch mask and duration, clear `elapsed_ms` and `status`.
  - Mask == 0 goes to DONE with status OK and no pulses.
  - Otherwise go to WAIT_READY and reset the ms prescaler and timeout counter.
- **WAIT_READY:**
  - When `(gen_ready & check_ready & mask) == mask`, go to RUN.
  - `abort` goes to DONE with status ABORTED; no start or stop is issued.
  - After READY_TIMEOUT_MS ms, go to DONE with status TIMEOUT.
- **RUN:**
  - Entry cycle drives `start = mask`.
  - The prescaler ticks every CLOCK_FREQ/1000 cycles; each tick increments `elapsed_ms`.
  - If duration != 0 and the increment makes `elapsed_ms == duration`, drive `stop = mask` next cycle, go to DRAIN, status OK.
  - `abort` drives `stop = mask` next cycle, goes to DRAIN, status ABORTED.
  - Duration 0: `elapsed_ms` saturates at all-ones; only `abort` ends the run.
- **DRAIN:**
  - Count DRAIN_MIN_CYCLES from the stop cycle, then wait for `(check_ready & mask) == mask`, then go to DONE.
  - After READY_TIMEOUT_MS ms, go to DONE with status TIMEOUT, overriding OK/ABORTED.
  - `abort` is ignored.
- **DONE:** assert `done` for one cycle, return to IDLE.
- **Simultaneous events:**
  - Expiry tick and `abort` in the same cycle: status OK.
  - Ready and timeout in the same cycle: ready wins.
  - `abort` in IDLE or DONE is ignored.
- **Widths:**
  - Prescaler width is clog2(CLOCK_FREQ/1000).
  - Timeout counter is a separate ms counter of width clog2(READY_TIMEOUT_MS+1), driven by the same tick.

## Timing
- **Reset values:** IDLE; `cmd_ready` = 1; `start`, `stop`, `busy`, `done`, `status`, `elapsed_ms` all 0. Asynchronous reset also aborts a run mid-operation with no stop pulse; downstream is reset by the same `rst`.
- **Outputs:** all registered.
- **Command to start:** `start` asserts 2 cycles after accepting the command when ready is already high (accept → WAIT_READY → RUN entry).
- **Run length:** `start` to `stop` is exactly duration × CLOCK_FREQ/1000 + 1 cycles.
- **Stop to done:** at least DRAIN_MIN_CYCLES + 1 cycles.
- **Command handshake:** `cmd_ready` is low from the cycle after accept until the cycle after `done`. A command presented during `done` is not accepted until IDLE.

## Structure
- Package `speed_test_pkg`:
  - state enum;
  - status codes `ST_OK`, `ST_ABORTED`, `ST_TIMEOUT`;
  - constant function `ms_cycles(CLOCK_FREQ)`.
- Sub-module `ms_tick_gen`: prescaler with synchronous clear, emitting a 1-cycle `tick`.
- FSM, latches and counters stay in `speed_test_sequencer`.

## Test plan
All scenarios use CLOCK_FREQ = 1000000 (1000 cycles/ms).
- **Normal run:** mask=4'b0101, duration=3, ready all 1.
  - `start` = 0101 at accept+2.
  - `stop` = 0101 exactly 3001 cycles later.
  - `done` ≥17 cycles after `stop`; status 0; `elapsed_ms` = 3.
- **Abort in RUN:** mask=4'b1111, duration=0, `abort` at 2500 cycles after `start`.
  - `stop` the next cycle; `elapsed_ms` = 2; status 1.
- **Ready timeout:** mask=4'b0010, `gen_ready[1]` held 0.
  - `done` after 100 ms; status 2; `start` and `stop` never pulse.
- **Expiry/abort collision:** `abort` on the expiry tick cycle of a duration=1 run.
  - status 0; exactly one `stop` pulse.
- **Drain timeout / zero mask:**
  - `check_ready[0]` drops at `stop` and never returns → status 2.
  - mask=0 → `done` 2 cycles after accept, no pulses.
- **Async reset in RUN:** all outputs go to 0 immediately; `cmd_ready` = 1; the next command works normally.

Source files
------------

// File: rtl/speed_test_pkg.sv
// Shared types and helpers for the speed-test run sequencer.
//   seq_state_t : sequencer FSM states
//   status_t    : completion status codes (ST_OK / ST_ABORTED / ST_TIMEOUT)
//   ms_cycles   : clk cycles per millisecond
//   cnt_width   : counter width able to hold 0..max_val-1 (never below 1)
package speed_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK      = 2'd0;
  localparam status_t ST_ABORTED = 2'd1;
  localparam status_t ST_TIMEOUT = 2'd2;

  function automatic int unsigned ms_cycles(input int unsigned clock_freq);
    return clock_freq / 1000;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler.
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : synchronous clear; the count restarts from zero next cycle
//   o_tick   : registered one-cycle pulse, first one CYCLES cycles after clear
module ms_tick_gen
  import speed_test_pkg::*;
#(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned PW = cnt_width(CYCLES);
  localparam logic [PW-1:0] LAST = PW'(CYCLES - 1);

  logic [PW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/speed_test_sequencer.sv
// Run sequencer for the speed tester. Accepts one command (port mask,
// duration in ms), waits for the selected generators/checkers to be ready,
// pulses start, times the run, pulses stop, waits for checkers to settle and
// reports done with a status code.
//   cmd_valid/cmd_ready           : command handshake (ready only in IDLE)
//   cmd_port_mask/cmd_duration_ms : command payload (duration 0 = until abort)
//   abort                         : one-cycle abort request
//   gen_ready/check_ready         : per-port readiness inputs
//   start/stop                    : one-cycle per-port pulses
//   busy/done/status/elapsed_ms   : run state and result (all registered)
module speed_test_sequencer
  import speed_test_pkg::*;
#(
  parameter int unsigned TEST_PORT_NUM    = 4,
  parameter int unsigned CLOCK_FREQ       = 125000000,
  parameter int unsigned DURATION_WIDTH   = 16,
  parameter int unsigned READY_TIMEOUT_MS = 100,
  parameter int unsigned DRAIN_MIN_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [TEST_PORT_NUM-1:0]  cmd_port_mask,
  input  logic [DURATION_WIDTH-1:0] cmd_duration_ms,
  input  logic                      abort,
  input  logic [TEST_PORT_NUM-1:0]  gen_ready,
  input  logic [TEST_PORT_NUM-1:0]  check_ready,
  output logic [TEST_PORT_NUM-1:0]  start,
  output logic [TEST_PORT_NUM-1:0]  stop,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                status,
  output logic [DURATION_WIDTH-1:0] elapsed_ms
);

  localparam int unsigned TICK_CYCLES = ms_cycles(CLOCK_FREQ);
  localparam int unsigned TW = cnt_width(READY_TIMEOUT_MS + 1);
  localparam int unsigned DW = cnt_width(DRAIN_MIN_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(READY_TIMEOUT_MS - 1);
  localparam logic [DW-1:0] DRAIN_MIN = DW'(DRAIN_MIN_CYCLES);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [TEST_PORT_NUM-1:0]  r_mask;
  logic [DURATION_WIDTH-1:0] r_dur;
  logic [DURATION_WIDTH-1:0] r_elapsed;
  status_t                   r_status;
  logic [TW-1:0]             r_to_cnt;
  logic [DW-1:0]             r_drain_cnt;
  logic                      r_cmd_ready;
  logic                      r_busy;
  logic                      r_done;
  logic [TEST_PORT_NUM-1:0]  r_start;
  logic [TEST_PORT_NUM-1:0]  r_stop;

  logic                      w_tick;
  logic                      w_clr;
  logic                      w_accept;
  logic                      w_all_ready;
  logic                      w_chk_ready;
  logic                      w_to_expire;
  logic                      w_run_expire;
  logic                      w_drain_min;
  logic                      w_status_we;
  status_t                   w_status_d;
  logic [TEST_PORT_NUM-1:0]  w_start_d;
  logic [TEST_PORT_NUM-1:0]  w_stop_d;
  logic                      w_done_d;
  logic                      w_cmd_ready_d;

  // Prescaler restarts on every state change so each phase (ready wait, run,
  // drain) is timed from its own entry cycle.
  assign w_clr = (w_next != r_state);

  ms_tick_gen #(
    .CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  assign w_accept     = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
  assign w_all_ready  = ((gen_ready & check_ready & r_mask) == r_mask);
  assign w_chk_ready  = ((check_ready & r_mask) == r_mask);
  assign w_to_expire  = w_tick && (r_to_cnt == TO_LAST);
  assign w_run_expire = w_tick && (r_dur != '0) && ((r_elapsed + 1'b1) == r_dur);
  assign w_drain_min  = (r_drain_cnt >= DRAIN_MIN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and status decisions
  always_comb begin
    w_next      = r_state;
    w_status_we = 1'b0;
    w_status_d  = r_status;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (cmd_port_mask == '0) ? S_DONE : S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (abort) begin
          w_next      = S_DONE;
          w_status_we = 1'b1;
          w_status_d  = ST_ABORTED;
        end else if (w_all_ready) begin
          w_next = S_RUN;
        end else if (w_to_expire) begin
          w_next      = S_DONE;
          w_status_we = 1'b1;
          w_status_d  = ST_TIMEOUT;
        end
      end
      S_RUN: begin
        // Expiry is tested first so a coinciding abort still reports OK.
        if (w_run_expire) begin
          w_next      = S_DRAIN;
          w_status_we = 1'b1;
          w_status_d  = ST_OK;
        end else if (abort) begin
          w_next      = S_DRAIN;
          w_status_we = 1'b1;
          w_status_d  = ST_ABORTED;
        end
      end
      S_DRAIN: begin
        if (w_drain_min && w_chk_ready) begin
          w_next = S_DONE;
        end else if (w_to_expire) begin
          w_next      = S_DONE;
          w_status_we = 1'b1;
          w_status_d  = ST_TIMEOUT;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Output decode (registered below). done lands the cycle after DONE, and
  // cmd_ready stays low through that cycle, so a command offered alongside
  // done waits one more cycle.
  always_comb begin
    w_start_d     = (r_state == S_WAIT_READY && w_next == S_RUN) ? r_mask : '0;
    w_stop_d      = (r_state == S_RUN && w_next == S_DRAIN) ? r_mask : '0;
    w_done_d      = (r_state == S_DONE);
    w_cmd_ready_d = (w_next == S_IDLE) && (r_state != S_DONE);
  end

  // Command latches, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask      <= '0;
      r_dur       <= '0;
      r_elapsed   <= '0;
      r_status    <= ST_OK;
      r_to_cnt    <= '0;
      r_drain_cnt <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_start     <= '0;
      r_stop      <= '0;
    end else begin
      if (w_accept) begin
        r_mask    <= cmd_port_mask;
        r_dur     <= cmd_duration_ms;
        r_elapsed <= '0;
      end else if (r_state == S_RUN && w_tick && r_elapsed != '1) begin
        r_elapsed <= r_elapsed + 1'b1;
      end

      if (w_accept) begin
        r_status <= ST_OK;
      end else if (w_status_we) begin
        r_status <= w_status_d;
      end

      if (w_clr) begin
        r_to_cnt <= '0;
      end else if ((r_state == S_WAIT_READY || r_state == S_DRAIN) &&
                   w_tick && r_to_cnt != TO_LAST) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_clr) begin
        r_drain_cnt <= '0;
      end else if (r_state == S_DRAIN && !w_drain_min) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end

      r_cmd_ready <= w_cmd_ready_d;
      r_busy      <= !w_cmd_ready_d;
      r_done      <= w_done_d;
      r_start     <= w_start_d;
      r_stop      <= w_stop_d;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign start      = r_start;
  assign stop       = r_stop;
  assign status     = r_status;
  assign elapsed_ms = r_elapsed;

endmodule
